mpe_feed_ctrl: RTL and testbench

Job-level sequencer for one matrix_pe. On a start pulse it takes inst_num uops from the upstream instruction stream and forwards each uop to the PE. For each uop it reads the matching run of 512-bit rows from NRAM and WRAM (synchronous SRAMs, 1-cycle read latency) and streams them through per-stream 2-entry buffers into the PE valid/ready ports. It waits for each result before moving on, then reports done.

---
 rtl/mpe_feed_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mpe_feed_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpe_feed_ctrl.sv
// Job sequencer for one matrix_pe: fetches uops, streams NRAM/WRAM rows into the PE, waits for results.
// Latency: first row valid 2 cycles after entering STREAM, then 1 row/cycle per stream; done registered 1 cycle after FIN.
// Backpressure: each stream keeps at most 2 rows buffered+inflight; reads stall until the PE pops a row.
module mpe_feed_ctrl #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16,
    parameter int UOP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        inst_num,
    input  logic [ADDR_W-1:0] nram_base,
    input  logic [ADDR_W-1:0] wram_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [UOP_W-1:0]  ib_uop,
    input  logic              ib_uop_valid,
    output logic              ib_uop_ready,
    output logic [UOP_W-1:0]  mpe_uop,
    output logic              mpe_uop_valid,
    input  logic              mpe_uop_ready,
    output logic              nram_rd_en,
    output logic [ADDR_W-1:0] nram_rd_addr,
    input  logic [DATA_W-1:0] nram_rd_data,
    output logic              wram_rd_en,
    output logic [ADDR_W-1:0] wram_rd_addr,
    input  logic [DATA_W-1:0] wram_rd_data,
    output logic [DATA_W-1:0] mpe_neuron,
    output logic              mpe_neuron_valid,
    input  logic              mpe_neuron_ready,
    output logic [DATA_W-1:0] mpe_weight,
    output logic              mpe_weight_valid,
    input  logic              mpe_weight_ready,
    input  logic              mpe_vld_o
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, STREAM, WAIT_RES, FIN} state_t;

    state_t                       state_q, state_d;
    logic [7:0]                   inst_num_q, inst_num_d;
    logic [7:0]                   uop_cnt_q, uop_cnt_d;
    logic [UOP_W-1:0]             uop_q, uop_d;
    logic                         err_q, err_d;
    logic                         res_seen_q, res_seen_d;
    logic                         done_q, done_d;

    // Index 0 is the NRAM/neuron stream, index 1 the WRAM/weight stream.
    logic [1:0][ADDR_W-1:0]       addr_q, addr_d;
    logic [1:0][UOP_W-1:0]        issued_q, issued_d;
    logic [1:0][UOP_W-1:0]        delivered_q, delivered_d;
    logic [1:0]                   inflight_q, inflight_d;
    logic [1:0][1:0]              cnt_q, cnt_d;
    logic [1:0]                   wr_ptr_q, wr_ptr_d;
    logic [1:0]                   rd_ptr_q, rd_ptr_d;
    logic [1:0][1:0][DATA_W-1:0]  buf_q, buf_d;

    logic [1:0][DATA_W-1:0]       rd_data;
    logic [1:0]                   out_rdy;
    logic [1:0]                   pop;
    logic [1:0]                   rd_en;
    logic                         go_stream;

    assign rd_data = {wram_rd_data, nram_rd_data};
    assign out_rdy = {mpe_weight_ready, mpe_neuron_ready};

    always_comb begin
        state_d     = state_q;
        inst_num_d  = inst_num_q;
        uop_cnt_d   = uop_cnt_q;
        uop_d       = uop_q;
        err_d       = err_q;
        res_seen_d  = res_seen_q;
        done_d      = (state_q == FIN);
        addr_d      = addr_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        inflight_d  = inflight_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        buf_d       = buf_q;
        pop         = '0;
        rd_en       = '0;
        go_stream   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    inst_num_d = inst_num;
                    uop_cnt_d  = '0;
                    err_d      = 1'b0;
                    res_seen_d = 1'b0;
                    addr_d[0]  = nram_base;
                    addr_d[1]  = wram_base;
                    state_d    = (inst_num == 8'd0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                if (ib_uop_valid) begin
                    uop_d = ib_uop;
                    if (ib_uop == '0) begin
                        // Empty uop: flagged and dropped, but it still counts toward the job.
                        err_d     = 1'b1;
                        uop_cnt_d = uop_cnt_q + 8'd1;
                        if (uop_cnt_q + 8'd1 == inst_num_q) state_d = FIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mpe_uop_ready) begin
                    go_stream = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (delivered_q[0] == uop_q && delivered_q[1] == uop_q) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_seen_q || mpe_vld_o) begin
                    res_seen_d = 1'b0;
                    uop_cnt_d  = uop_cnt_q + 8'd1;
                    state_d    = (uop_cnt_q + 8'd1 == inst_num_q) ? FIN : FETCH;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (mpe_vld_o) begin
            if (state_q == STREAM) res_seen_d = 1'b1;
            else if (state_q != WAIT_RES) err_d = 1'b1;
        end

        for (int s = 0; s < 2; s++) begin
            pop[s]   = (cnt_q[s] != 2'd0) && out_rdy[s];
            // Occupancy after this cycle's pop must leave room for the row being requested.
            rd_en[s] = (state_q == STREAM) && (issued_q[s] < uop_q) &&
                       ({1'b0, cnt_q[s]} + {2'b0, inflight_q[s]} < 3'd2 + {2'b0, pop[s]});
            inflight_d[s] = rd_en[s];
            if (rd_en[s]) addr_d[s] = addr_q[s] + ADDR_W'(1);
            issued_d[s]    = go_stream ? '0 : issued_q[s] + UOP_W'(rd_en[s]);
            delivered_d[s] = go_stream ? '0 : delivered_q[s] + UOP_W'(pop[s]);
            cnt_d[s]       = cnt_q[s] + 2'(inflight_q[s]) - 2'(pop[s]);
            if (inflight_q[s]) begin
                buf_d[s][wr_ptr_q[s]] = rd_data[s];
                wr_ptr_d[s]           = ~wr_ptr_q[s];
            end
            if (pop[s]) rd_ptr_d[s] = ~rd_ptr_q[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            inst_num_q  <= '0;
            uop_cnt_q   <= '0;
            uop_q       <= '0;
            err_q       <= 1'b0;
            res_seen_q  <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            inst_num_q  <= inst_num_d;
            uop_cnt_q   <= uop_cnt_d;
            uop_q       <= uop_d;
            err_q       <= err_d;
            res_seen_q  <= res_seen_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_q       <= buf_d;
        end
    end

    assign busy             = (state_q != IDLE) && (state_q != FIN);
    assign done             = done_q;
    assign err              = err_q;
    assign ib_uop_ready     = (state_q == FETCH);
    assign mpe_uop          = uop_q;
    assign mpe_uop_valid    = (state_q == ISSUE);
    assign nram_rd_en       = rd_en[0];
    assign nram_rd_addr     = addr_q[0];
    assign wram_rd_en       = rd_en[1];
    assign wram_rd_addr     = addr_q[1];
    assign mpe_neuron       = buf_q[0][rd_ptr_q[0]];
    assign mpe_neuron_valid = (cnt_q[0] != 2'd0);
    assign mpe_weight       = buf_q[1][rd_ptr_q[1]];
    assign mpe_weight_valid = (cnt_q[1] != 2'd0);

endmodule

// File: tb/tb_mpe_feed_ctrl.sv
// Randomized bench for mpe_feed_ctrl: SRAM and PE models, queue-based reference of addresses, rows and uops.
module tb_mpe_feed_ctrl;
    typedef logic [512:0] cv_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   inst_num;
    logic [15:0]  nram_base, wram_base;
    logic         busy, done, err;
    logic [7:0]   ib_uop;
    logic         ib_uop_valid, ib_uop_ready;
    logic [7:0]   mpe_uop;
    logic         mpe_uop_valid, mpe_uop_ready;
    logic         nram_rd_en, wram_rd_en;
    logic [15:0]  nram_rd_addr, wram_rd_addr;
    logic [511:0] nram_rd_data, wram_rd_data;
    logic [511:0] mpe_neuron, mpe_weight;
    logic         mpe_neuron_valid, mpe_neuron_ready;
    logic         mpe_weight_valid, mpe_weight_ready;
    logic         mpe_vld_o;

    mpe_feed_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .inst_num(inst_num),
        .nram_base(nram_base), .wram_base(wram_base),
        .busy(busy), .done(done), .err(err),
        .ib_uop(ib_uop), .ib_uop_valid(ib_uop_valid), .ib_uop_ready(ib_uop_ready),
        .mpe_uop(mpe_uop), .mpe_uop_valid(mpe_uop_valid), .mpe_uop_ready(mpe_uop_ready),
        .nram_rd_en(nram_rd_en), .nram_rd_addr(nram_rd_addr), .nram_rd_data(nram_rd_data),
        .wram_rd_en(wram_rd_en), .wram_rd_addr(wram_rd_addr), .wram_rd_data(wram_rd_data),
        .mpe_neuron(mpe_neuron), .mpe_neuron_valid(mpe_neuron_valid), .mpe_neuron_ready(mpe_neuron_ready),
        .mpe_weight(mpe_weight), .mpe_weight_valid(mpe_weight_valid), .mpe_weight_ready(mpe_weight_ready),
        .mpe_vld_o(mpe_vld_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input cv_t obs, input cv_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mem_row(input logic [15:0] a, input logic [7:0] salt);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = {a ^ 16'(i * 4951), salt, 8'(i)};
        return r;
    endfunction

    always @(posedge clk) begin
        if (nram_rd_en) nram_rd_data <= mem_row(nram_rd_addr, 8'h4E);
        if (wram_rd_en) wram_rd_data <= mem_row(wram_rd_addr, 8'h57);
    end

    // Reference queues: built from the job description, consumed by the monitor.
    logic [7:0]  feed_q[$];
    logic [7:0]  job_uops[$];
    logic [7:0]  exp_uop[$];
    logic [15:0] exp_nrd[$], exp_ndl[$], exp_wrd[$], exp_wdl[$];

    int  mode = 0;
    int  stall_until = 0;
    bit  mon_en = 0;
    bit  flush = 0;

    int  ib_hs_cnt = 0, res_req_cnt = 0, done_cnt = 0, act_cnt = 0;
    int  n_rds = 0, n_pops = 0, w_rds = 0, w_pops = 0;
    int  cur_l = 0, n_got = 0, w_got = 0;
    int  uop_hs_cyc = 0, n_first = 0, n_last = 0, w_first = 0, w_last = 0;
    bit  res_armed = 0;

    // Monitor: samples on the falling edge.
    initial begin
        logic         pn_vld, pn_rdy, pw_vld, pw_rdy, pu_vld, pu_rdy;
        logic [511:0] pn_dat, pw_dat;
        logic [7:0]   pu_dat;
        pn_vld = 0; pn_rdy = 0; pw_vld = 0; pw_rdy = 0; pu_vld = 0; pu_rdy = 0;
        pn_dat = '0; pw_dat = '0; pu_dat = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                n_rds = 0; n_pops = 0; w_rds = 0; w_pops = 0;
                cur_l = 0; n_got = 0; w_got = 0; res_armed = 0;
                pn_vld = 0; pw_vld = 0; pu_vld = 0;
            end else begin
                if (ib_uop_valid && ib_uop_ready) begin
                    ib_hs_cnt++;
                    if (feed_q.size() > 0) void'(feed_q.pop_front());
                end
                if (mpe_uop_valid && mpe_uop_ready) begin
                    if (exp_uop.size() == 0) chk("uop_extra", cv_t'(mpe_uop), cv_t'(0));
                    else chk("uop_val", cv_t'(mpe_uop), cv_t'(exp_uop.pop_front()));
                    cur_l = int'(mpe_uop); n_got = 0; w_got = 0; res_armed = 0; uop_hs_cyc = cyc;
                end
                if (nram_rd_en) begin
                    n_rds++;
                    if (exp_nrd.size() == 0) chk("nram_rd_extra", cv_t'(nram_rd_addr), cv_t'(0));
                    else chk("nram_rd_addr", cv_t'(nram_rd_addr), cv_t'(exp_nrd.pop_front()));
                end
                if (wram_rd_en) begin
                    w_rds++;
                    if (exp_wrd.size() == 0) chk("wram_rd_extra", cv_t'(wram_rd_addr), cv_t'(0));
                    else chk("wram_rd_addr", cv_t'(wram_rd_addr), cv_t'(exp_wrd.pop_front()));
                end
                if (mpe_neuron_valid && mpe_neuron_ready) begin
                    n_pops++;
                    if (n_got == 0) n_first = cyc;
                    n_last = cyc; n_got++;
                    if (exp_ndl.size() == 0) chk("neuron_extra", cv_t'(mpe_neuron), cv_t'(0));
                    else chk("neuron_dat", cv_t'(mpe_neuron), cv_t'(mem_row(exp_ndl.pop_front(), 8'h4E)));
                end
                if (mpe_weight_valid && mpe_weight_ready) begin
                    w_pops++;
                    if (w_got == 0) w_first = cyc;
                    w_last = cyc; w_got++;
                    if (exp_wdl.size() == 0) chk("weight_extra", cv_t'(mpe_weight), cv_t'(0));
                    else chk("weight_dat", cv_t'(mpe_weight), cv_t'(mem_row(exp_wdl.pop_front(), 8'h57)));
                end
                if (cur_l != 0 && n_got == cur_l && w_got == cur_l && !res_armed) begin
                    res_armed = 1;
                    res_req_cnt++;
                end
                if (pn_vld && !pn_rdy) chk("neuron_hold", {mpe_neuron_valid, mpe_neuron}, {1'b1, pn_dat});
                if (pw_vld && !pw_rdy) chk("weight_hold", {mpe_weight_valid, mpe_weight}, {1'b1, pw_dat});
                if (pu_vld && !pu_rdy) chk("uop_hold", cv_t'({mpe_uop_valid, mpe_uop}), cv_t'({1'b1, pu_dat}));
                chk("n_outst_le2", cv_t'(n_rds - n_pops <= 2), cv_t'(1));
                chk("w_outst_le2", cv_t'(w_rds - w_pops <= 2), cv_t'(1));
                if (done) done_cnt++;
                if (ib_uop_ready || nram_rd_en || wram_rd_en || mpe_uop_valid ||
                    mpe_neuron_valid || mpe_weight_valid) act_cnt++;
                pn_vld = mpe_neuron_valid; pn_rdy = mpe_neuron_ready; pn_dat = mpe_neuron;
                pw_vld = mpe_weight_valid; pw_rdy = mpe_weight_ready; pw_dat = mpe_weight;
                pu_vld = mpe_uop_valid;    pu_rdy = mpe_uop_ready;    pu_dat = mpe_uop;
            end
        end
    end

    // Driver: upstream uop source, PE readies and PE result pulses; updates just after the rising edge.
    initial begin
        int ib_seen, res_fire_cnt, res_wait;
        bit hs;
        ib_seen = 0; res_fire_cnt = 0; res_wait = 0;
        ib_uop_valid = 0; ib_uop = '0; mpe_vld_o = 0;
        mpe_uop_ready = 0; mpe_neuron_ready = 0; mpe_weight_ready = 0;
        forever begin
            @(posedge clk); #1;
            mpe_vld_o = 0;
            if (flush) begin
                ib_uop_valid = 0;
                ib_seen = ib_hs_cnt;
                res_fire_cnt = res_req_cnt;
            end else begin
                hs = (ib_seen != ib_hs_cnt);
                ib_seen = ib_hs_cnt;
                if (!(ib_uop_valid && !hs)) begin
                    ib_uop_valid = (feed_q.size() > 0) && (mode != 0 || $urandom_range(0, 3) != 0);
                    ib_uop = (feed_q.size() > 0) ? feed_q[0] : 8'($urandom);
                end
                if (res_fire_cnt != res_req_cnt) begin
                    if (res_wait == 0) begin
                        mpe_vld_o = 1;
                        res_fire_cnt++;
                        res_wait = (mode == 0) ? $urandom_range(0, 4) : 0;
                    end else res_wait--;
                end
            end
            case (mode)
                1: begin mpe_uop_ready = 1; mpe_neuron_ready = 1; mpe_weight_ready = 1; end
                2: begin mpe_uop_ready = 1; mpe_weight_ready = 1; mpe_neuron_ready = (cyc >= stall_until); end
                default: begin
                    mpe_uop_ready    = ($urandom_range(0, 3) != 0);
                    mpe_neuron_ready = ($urandom_range(0, 3) != 0);
                    mpe_weight_ready = ($urandom_range(0, 3) != 0);
                end
            endcase
        end
    end

    int  d0 = 0, start_cyc = 0;
    bit  exp_err_v = 0;

    // Called half a cycle after a rising edge; builds expectations from job_uops and pulses start.
    task automatic job_begin(input logic [15:0] nb, input logic [15:0] wb, input int md);
        logic [15:0] an, aw;
        an = nb; aw = wb; exp_err_v = 0; mode = md;
        for (int i = 0; i < job_uops.size(); i++) begin
            feed_q.push_back(job_uops[i]);
            if (job_uops[i] == 8'd0) exp_err_v = 1;
            else begin
                exp_uop.push_back(job_uops[i]);
                for (int r = 0; r < int'(job_uops[i]); r++) begin
                    exp_nrd.push_back(an); exp_ndl.push_back(an); an = an + 16'd1;
                    exp_wrd.push_back(aw); exp_wdl.push_back(aw); aw = aw + 16'd1;
                end
            end
        end
        d0 = done_cnt;
        inst_num = 8'(job_uops.size()); nram_base = nb; wram_base = wb;
        start = 1; start_cyc = cyc;
        @(negedge clk); #1;
        start = 0;
    endtask

    task automatic job_end(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk); #1;
            if (done) got = 1;
        end
        chk({tag, "_done_seen"}, cv_t'(got), cv_t'(1));
        chk({tag, "_done_cnt"}, cv_t'(done_cnt - d0), cv_t'(1));
        chk({tag, "_err"}, cv_t'(err), cv_t'(exp_err_v));
        chk({tag, "_busy"}, cv_t'(busy), cv_t'(0));
        chk({tag, "_left"}, cv_t'(exp_uop.size() + exp_nrd.size() + exp_ndl.size() +
                                  exp_wrd.size() + exp_wdl.size()), cv_t'(0));
        @(negedge clk); #1;
        chk({tag, "_done_pulse"}, cv_t'(done), cv_t'(0));
        job_uops.delete();
    endtask

    function automatic cv_t outs_vec();
        return cv_t'({busy, done, err, ib_uop_ready, mpe_uop_valid, mpe_uop, nram_rd_en, nram_rd_addr,
                      wram_rd_en, wram_rd_addr, mpe_neuron_valid, mpe_weight_valid});
    endfunction

    initial begin
        int a0, zc;
        rst = 1; start = 0; inst_num = '0; nram_base = '0; wram_base = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", outs_vec(), cv_t'(0));
        chk("rst_ndat", cv_t'(mpe_neuron), cv_t'(0));
        rst = 0; mon_en = 1;
        @(negedge clk); #1;

        // Four uops of 35 from base 0 with random handshakes.
        repeat (4) job_uops.push_back(8'd35);
        job_begin(16'h0000, 16'h0000, 0);
        job_end("four35");
        chk("four35_reads", cv_t'(n_rds), cv_t'(140));

        // Random job with random bases.
        repeat (3) job_uops.push_back(8'($urandom_range(1, 12)));
        job_begin(16'($urandom), 16'($urandom), 0);
        job_end("rand");

        // Full throughput.
        job_uops.push_back(8'd8);
        job_begin(16'h1234, 16'h4321, 1);
        job_end("tput");
        chk("tput_n_first", cv_t'(n_first - uop_hs_cyc), cv_t'(3));
        chk("tput_n_span", cv_t'(n_last - n_first), cv_t'(7));
        chk("tput_w_first", cv_t'(w_first - uop_hs_cyc), cv_t'(3));
        chk("tput_w_span", cv_t'(w_last - w_first), cv_t'(7));

        // Neuron backpressure while weights flow freely.
        job_uops.push_back(8'd40);
        stall_until = cyc + 26;
        job_begin(16'h0040, 16'h0800, 2);
        for (int i = 0; i < 100 && cyc < start_cyc + 25; i++) begin @(negedge clk); #1; end
        chk("bp_cycle", cv_t'(cyc), cv_t'(start_cyc + 25));
        chk("bp_rd_en", cv_t'(nram_rd_en), cv_t'(0));
        chk("bp_outst", cv_t'(n_rds - n_pops), cv_t'(2));
        chk("bp_nvalid", cv_t'(mpe_neuron_valid), cv_t'(1));
        chk("bp_w_indep", cv_t'(w_got > 15), cv_t'(1));
        job_end("bp");

        // Address wrap with an empty uop first.
        job_uops.push_back(8'd0); job_uops.push_back(8'd4);
        job_begin(16'hFFFE, 16'h0010, 0);
        job_end("wrap");

        // Empty job: done two cycles after start, no traffic, err cleared.
        a0 = act_cnt; d0 = done_cnt;
        inst_num = 8'd0; start = 1; zc = cyc;
        @(negedge clk); #1; start = 0;
        chk("zero_done_c1", cv_t'(done), cv_t'(0));
        @(negedge clk); #1;
        chk("zero_done_c2", cv_t'(done), cv_t'(1));
        chk("zero_cycle", cv_t'(cyc - zc), cv_t'(2));
        @(negedge clk); #1;
        chk("zero_done_c3", cv_t'(done), cv_t'(0));
        chk("zero_act", cv_t'(act_cnt - a0), cv_t'(0));
        chk("zero_err", cv_t'(err), cv_t'(0));
        chk("zero_done_cnt", cv_t'(done_cnt - d0), cv_t'(1));

        // Reset in the middle of streaming, then a fresh job from new bases.
        job_uops.push_back(8'd30); job_uops.push_back(8'd30);
        job_begin(16'h0500, 16'h0A00, 0);
        for (int i = 0; i < 500 && n_got < 5; i++) begin @(negedge clk); #1; end
        chk("mid_reached", cv_t'(n_got >= 5), cv_t'(1));
        rst = 1; mon_en = 0; flush = 1;
        #1;
        chk("mid_rst_outs", outs_vec(), cv_t'(0));
        chk("mid_rst_ndat", cv_t'(mpe_neuron), cv_t'(0));
        repeat (3) @(negedge clk);
        #1;
        chk("mid_rst_hold", outs_vec(), cv_t'(0));
        chk("mid_no_done", cv_t'(done_cnt - d0), cv_t'(0));
        feed_q.delete(); exp_uop.delete(); job_uops.delete();
        exp_nrd.delete(); exp_ndl.delete(); exp_wrd.delete(); exp_wdl.delete();
        rst = 0;
        @(negedge clk); #1;
        flush = 0; mon_en = 1;
        @(negedge clk); #1;
        job_uops.push_back(8'd5); job_uops.push_back(8'd3);
        job_begin(16'h0100, 16'h0300, 0);
        job_end("post_rst");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
